// File: rtl/mem_burst_master.sv
// mem_burst_master: single-command burst initiator for the register-array memory
// port. Takes one write or read burst, drives the memory pins cycle by cycle and
// returns read data as a valid-qualified stream.
//
// Optional feature macro: MEM_BURST_ADDR_WRAP_EN
//   defined   - bursts running past the top address wrap modulo 2^ADDR_W
//   undefined - such commands are rejected with a one-cycle o_err pulse
//
// state  | meaning
// IDLE   | waiting for i_start; only state that accepts a command
// WRITE  | o_wdata_ready high, one memory write per handshake
// READ   | one memory read issued per cycle, no stalls
// DRAIN  | all reads issued, waiting for outstanding returns
// DONE   | o_done pulse, back to IDLE next cycle
module mem_burst_master #(
    parameter int ADDR_W  = 4,
    parameter int WDATA_W = 4,
    parameter int RDATA_W = 8,
    parameter int RD_LAT  = 1
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_op,
    input  logic [ADDR_W-1:0]  i_base_addr,
    input  logic [ADDR_W-1:0]  i_len,
    input  logic [WDATA_W-1:0] i_wdata,
    input  logic               i_wdata_valid,
    output logic               o_wdata_ready,
    output logic [RDATA_W-1:0] o_rdata,
    output logic               o_rdata_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic               o_wr,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [WDATA_W-1:0] o_wr_data,
    output logic               o_rd,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [RDATA_W-1:0] i_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ADDR_TOP = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    logic [ADDR_W:0]   len_p1;   // beats in the burst (len + 1)
    logic [ADDR_W:0]   beat_cnt; // beats transferred (write) or issued (read)
    logic [ADDR_W-1:0] wr_ptr;   // address of the next write beat
    logic [RD_LAT:0]   rd_pipe;  // one bit per read in flight, oldest at the top
    logic              cmd_reject;

`ifdef MEM_BURST_ADDR_WRAP_EN
    assign cmd_reject = 1'b0;
`else
    // A burst whose last address lands past the top of memory is refused.
    assign cmd_reject = (({1'b0, i_base_addr} + {1'b0, i_len}) > ADDR_TOP);
`endif

    // Command FSM with all memory-side and status outputs registered.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            len_p1        <= '0;
            beat_cnt      <= '0;
            wr_ptr        <= '0;
            o_wdata_ready <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_wr          <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_rd          <= 1'b0;
            o_rd_addr     <= '0;
        end else begin
            o_wr   <= 1'b0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (cmd_reject) begin
                            o_err <= 1'b1;
                        end else begin
                            len_p1 <= {1'b0, i_len} + CNT_ONE;
                            o_busy <= 1'b1;
                            if (i_op) begin
                                // First read goes out in the cycle right after acceptance.
                                state     <= S_READ;
                                o_rd      <= 1'b1;
                                o_rd_addr <= i_base_addr;
                                beat_cnt  <= CNT_ONE;
                            end else begin
                                state         <= S_WRITE;
                                o_wdata_ready <= 1'b1;
                                wr_ptr        <= i_base_addr;
                                beat_cnt      <= '0;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (beat_cnt == len_p1) begin
                        // Last write is on the pins this cycle; completion follows it.
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else if (i_wdata_valid && o_wdata_ready) begin
                        o_wr      <= 1'b1;
                        o_wr_addr <= wr_ptr;
                        o_wr_data <= i_wdata;
                        wr_ptr    <= wr_ptr + ADDR_ONE;
                        beat_cnt  <= beat_cnt + CNT_ONE;
                        if ((beat_cnt + CNT_ONE) == len_p1) begin
                            o_wdata_ready <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (beat_cnt == len_p1) begin
                        o_rd  <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        o_rd_addr <= o_rd_addr + ADDR_ONE;
                        beat_cnt  <= beat_cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    // Only the return landing this cycle may remain in flight.
                    if (rd_pipe[RD_LAT-1:0] == '0) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read return tracking: capture memory data when the matching issue bit arrives.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            rd_pipe <= '0;
            o_rdata <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:0], o_rd};
            if (rd_pipe[RD_LAT-1]) begin
                o_rdata <= i_rd_data;
            end
        end
    end

    assign o_rdata_valid = rd_pipe[RD_LAT];

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Synthesizable initiator for the register-array memory port: accepts one burst command (write or read, base address, length), drives the memory's `wr`/`rd`/address/data pins cycle by cycle, and returns read data as a valid-qualified stream. Sits between a control FSM or host interface and the `memory` block, replacing hand-written bench stimulus with a reusable RTL master.

## Interface
Parameters:
- `ADDR_W`, 4: memory address width.
- `WDATA_W`, 4: write data width.
- `RDATA_W`, 8: read data width.
- `RD_LAT`, 1: memory read latency in clocks; legal range 1..4.

Ports (clock and reset first):
- `i_sys_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  command strobe; accepted only in IDLE.
- `i_op`  in  1  0 = write burst, 1 = read burst.
- `i_base_addr`  in  ADDR_W  first address of the burst.
- `i_len`  in  ADDR_W  beats minus one (0 → 1 beat, 15 → 16 beats).
- `i_wdata`  in  WDATA_W  write data stream.
- `i_wdata_valid`  in  1  write data valid.
- `o_wdata_ready`  out  1  master can take write data.
- `o_rdata`  out  RDATA_W  read data stream.
- `o_rdata_valid`  out  1  one-cycle qualifier per read beat.
- `o_busy`  out  1  command in progress.
- `o_done`  out  1  one-cycle pulse at burst completion.
- `o_err`  out  1  one-cycle pulse on a rejected command.
- `o_wr`  out  1  memory write enable.
- `o_wr_addr`  out  ADDR_W  memory write address.
- `o_wr_data`  out  WDATA_W  memory write data.
- `o_rd`  out  1  memory read enable.
- `o_rd_addr`  out  ADDR_W  memory read address.
- `i_rd_data`  in  RDATA_W  memory read data.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: `i_start`=1 latches op, base, and len; goes to WRITE (`i_op`=0) or READ (`i_op`=1). A rejected command (see Configuration) stays in IDLE and pulses `o_err`.
- WRITE: `o_wdata_ready`=1. A beat transfers on each cycle with `i_wdata_valid & o_wdata_ready`, giving next cycle `o_wr`=1, `o_wr_addr`=current address, and `o_wr_data`=`i_wdata`. The address then increments. With no valid, `o_wr`=0 and the address holds. After beat len+1 the state goes to DONE.
- READ: `o_rd`=1 on len+1 consecutive cycles, with `o_rd_addr` = base, base+1, and so on. No stalls. After the last issue the state goes to DRAIN.
- DRAIN: waits until all outstanding reads return, then goes to DONE.
- DONE: `o_done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W.
- Return tracking uses a RD_LAT+1 deep valid shift register. Each returned beat registers `i_rd_data` into `o_rdata`, in issue order.
- `o_busy`=1 in every state except IDLE.
- `i_start` while busy is ignored, with no `o_err`.
- `i_rst` mid-burst: the next edge forces IDLE, all outputs 0, and flushes pending read returns. No `o_done` is produced.

## Timing
- Reset values: every output is 0, and `o_rdata`, `o_wr_addr`, `o_wr_data`, `o_rd_addr` are all zeros.
- Command accepted at edge k: `o_busy`=1 from cycle k+1. The first `o_rd` or `o_wdata_ready` is in cycle k+1.
- Write: handshake in cycle n gives `o_wr` high in cycle n+1. All memory-side outputs are registered.
- Read: `o_rd` high in cycle m gives `o_rdata_valid` high in cycle m+RD_LAT+1.
- Read burst of L beats started at edge k:
  - last `o_rd` in cycle k+L;
  - last `o_rdata_valid` in cycle k+L+RD_LAT+1;
  - `o_done` in cycle k+L+RD_LAT+2.
- Write burst: `o_done` is one cycle after the cycle containing the last `o_wr`.
- Earliest re-accept of `i_start` is the cycle after `o_done`.
- `o_wr` and `o_rd` are never high in the same cycle.

## Configuration
- Macro `MEM_BURST_ADDR_WRAP_EN`.
- Defined: a burst whose base+len exceeds 2^ADDR_W−1 is accepted, and addresses wrap modulo 2^ADDR_W.
- Undefined: such a command is rejected. `o_err` pulses one cycle after `i_start`, the state stays IDLE, and no memory access occurs.

## Test plan
- Write burst, base=3, len=3, data 1,2,3,4 with valid held high: `o_wr` high 4 consecutive cycles, addresses 3..6, data 1..4, `o_done` the following cycle.
- Write stall: same burst with `i_wdata_valid` low for 2 cycles after beat 2: `o_wr` gap of 2 cycles, addresses continue 5,6, still exactly 4 writes.
- Read burst, base=3, len=3, RD_LAT=1, memory model returning {4'h0, mem[addr]}: `o_rdata` = 8'h01..8'h04 on 4 consecutive valids, each 2 cycles after its `o_rd`, then `o_done`.
- Wrap case, base=14, len=3:
  - with `MEM_BURST_ADDR_WRAP_EN`: addresses 14,15,0,1;
  - without it: `o_err`=1 for one cycle, and `o_wr`/`o_rd` never assert.
- `i_rst`=1 during beat 2 of a read burst with RD_LAT=3: all outputs 0 on the next cycle, no further `o_rdata_valid`, no `o_done`. A new write command after release completes normally.
- `i_start` asserted while `o_busy`=1: ignored, the current burst completes unchanged, and `o_err` stays 0.
